// File: rtl/mux_feed_seq_pkg.sv
// Shared definitions for the mux feed sequencer: source count, mode codes and FSM states.
package mux_feed_seq_pkg;

    localparam int NUM_SRC = 4;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/mux_feed_seq_next_src_find.sv
// Finds the lowest eligible source index; with first=0 only indices above cur qualify.
module mux_feed_seq_next_src_find
    import mux_feed_seq_pkg::*;
(
    input  logic [NUM_SRC-1:0] eligible,
    input  logic [1:0]         cur,
    input  logic               first,
    output logic [1:0]         nxt,
    output logic               found
);

    // Descending walk so the lowest qualifying index is the last one written.
    always_comb begin
        nxt   = 2'd0;
        found = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible[i] && (first || (i > int'(cur)))) begin
                nxt   = 2'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_feed_seq.sv
// Source stage for the 4:1 mux datapath: operand registers, loaded flags and the select sequencer.
module mux_feed_seq
    import mux_feed_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SKIP_EMPTY = 1
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr,
    input  logic             start,
    input  logic             mode,
    input  logic [1:0]       src_idx,
    input  logic             abort,
    input  logic             out_ready,
    output logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] in4,
    output logic             sel1,
    output logic             sel2,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             wr_err
);

    state_t             state_reg, state_next;
    logic               mode_reg, mode_next;
    logic [1:0]         sel_reg, sel_next;
    logic               out_valid_reg, done_reg, wr_err_reg;
    logic [NUM_SRC-1:0] loaded;
    logic [WIDTH-1:0]   regs [NUM_SRC];
    logic               wr_hazard, wr_accept;
    logic [NUM_SRC-1:0] eligible;
    logic [1:0]         nxt;
    logic               found;

    // A write may not disturb a beat the consumer is still stalling on.
    assign wr_hazard = wr_en & out_valid_reg & ~out_ready & (wr_addr == sel_reg);
    assign wr_accept = wr_en & ~wr_hazard;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [WIDTH-1:0] data_reg;
            logic             loaded_reg;

            // An accepted write wins over clr so the written slot stays flagged.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    data_reg   <= '0;
                    loaded_reg <= 1'b0;
                end else if (wr_accept && (wr_addr == 2'(gi))) begin
                    data_reg   <= wr_data;
                    loaded_reg <= 1'b1;
                end else if (clr) begin
                    loaded_reg <= 1'b0;
                end
            end

            assign regs[gi]   = data_reg;
            assign loaded[gi] = loaded_reg;
        end
    endgenerate

    assign eligible = (SKIP_EMPTY != 0) ? loaded : {NUM_SRC{1'b1}};

    mux_feed_seq_next_src_find u_find (
        .eligible (eligible),
        .cur      (sel_reg),
        .first    (state_reg == IDLE),
        .nxt      (nxt),
        .found    (found)
    );

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        sel_next   = sel_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    mode_next = mode;
                    if (mode == MODE_SINGLE) begin
                        sel_next   = src_idx;
                        state_next = PRESENT;
                    end else if (found) begin
                        sel_next   = nxt;
                        state_next = PRESENT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    if (mode_reg == MODE_SCAN && found) begin
                        sel_next = nxt;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
            mode_next  = mode_reg;
            sel_next   = sel_reg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_SINGLE;
            sel_reg       <= 2'd0;
            out_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            wr_err_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            sel_reg       <= sel_next;
            out_valid_reg <= (state_next == PRESENT);
            done_reg      <= (state_next == DONE);
            wr_err_reg    <= wr_hazard;
        end
    end

    assign in1       = regs[0];
    assign in2       = regs[1];
    assign in3       = regs[2];
    assign in4       = regs[3];
    assign sel1      = sel_reg[1];
    assign sel2      = sel_reg[0];
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign wr_err    = wr_err_reg;

endmodule
